bp_me_xui_arbiter: RTL and testbench

BP_ME_XUI_ARBITER -- requirements
Module: bp_me_xui_arbiter

---
 rtl/bp_me_xui_arbiter.sv | 135 +++++++++++++
 tb/tb_bp_me_xui_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_xui_arbiter.sv
// Two-port XUI command arbiter with alternating priority on contention.
// A tag FIFO records which port issued each read so returning data is steered back in order.
module bp_me_xui_arbiter #(
    parameter int unsigned addr_width_p = 28,
    parameter int unsigned data_width_p = 512,
    parameter int unsigned max_reads_p  = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,

    input  logic [1:0][addr_width_p-1:0]         req_addr_i,
    input  logic [1:0][2:0]                      req_cmd_i,
    input  logic [1:0]                           req_en_i,
    output logic [1:0]                           req_rdy_o,
    input  logic [1:0][data_width_p-1:0]         req_wdf_data_i,
    input  logic [1:0][data_width_p/8-1:0]       req_wdf_mask_i,
    output logic [1:0]                           req_rd_data_valid_o,
    output logic [data_width_p-1:0]              req_rd_data_o,

    output logic [addr_width_p-1:0]              app_addr_o,
    output logic [2:0]                           app_cmd_o,
    output logic                                 app_en_o,
    input  logic                                 app_rdy_i,
    output logic                                 app_wdf_wren_o,
    output logic [data_width_p-1:0]              app_wdf_data_o,
    output logic [data_width_p/8-1:0]            app_wdf_mask_o,
    output logic                                 app_wdf_end_o,
    input  logic                                 app_wdf_rdy_i,
    input  logic                                 app_rd_data_valid_i,
    input  logic [data_width_p-1:0]              app_rd_data_i,
    input  logic                                 app_rd_data_end_i,

    output logic [$clog2(max_reads_p):0]         reads_outstanding_o,
    output logic                                 err_o
);

    localparam int unsigned PtrWidth = $clog2(max_reads_p);
    localparam int unsigned CntWidth = PtrWidth + 1;
    localparam logic [2:0]  CmdWrite = 3'b000;

    logic                last_grant_q, last_grant_d;
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                err_q, err_d;
    logic                tags_q [max_reads_p];

    logic sel;
    logic sel_write;
    logic full;
    logic empty;
    logic eligible;
    logic accept;
    logic push;
    logic pop;
    logic head;

    // On contention the port that did not win last time is chosen.
    always_comb begin
        if (req_en_i[0] && req_en_i[1]) begin
            sel = ~last_grant_q;
        end else begin
            sel = req_en_i[1];
        end
    end

    assign sel_write = (req_cmd_i[sel] == CmdWrite);
    assign full      = (count_q == CntWidth'(max_reads_p));
    assign empty     = (count_q == '0);
    assign eligible  = req_en_i[sel] && (sel_write ? app_wdf_rdy_i : !full);
    assign head      = tags_q[rd_ptr_q];

    assign app_en_o       = eligible && reset_n_i;
    assign accept         = app_en_o && app_rdy_i;
    assign push           = accept && !sel_write;
    assign pop            = app_rd_data_valid_i && app_rd_data_end_i && !empty;

    assign app_addr_o     = req_addr_i[sel];
    assign app_cmd_o      = req_cmd_i[sel];
    assign app_wdf_data_o = req_wdf_data_i[sel];
    assign app_wdf_mask_o = req_wdf_mask_i[sel];
    assign app_wdf_wren_o = app_en_o && sel_write;
    assign app_wdf_end_o  = app_en_o && sel_write;

    assign req_rdy_o = {accept && sel, accept && !sel};

    // Data with no tag queued is spurious and reaches neither port.
    always_comb begin
        req_rd_data_valid_o = 2'b00;
        if (app_rd_data_valid_i && !empty && reset_n_i) begin
            req_rd_data_valid_o[head] = 1'b1;
        end
    end

    assign req_rd_data_o       = app_rd_data_i;
    assign reads_outstanding_o = count_q;
    assign err_o               = err_q;

    always_comb begin
        last_grant_d = accept ? sel : last_grant_q;
        wr_ptr_d     = push ? wr_ptr_q + PtrWidth'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PtrWidth'(1) : rd_ptr_q;
        count_d      = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
        err_d = err_q || (app_rd_data_valid_i && empty);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end

    // Tag storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tags_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_bp_me_xui_arbiter.sv
// Directed and randomized bench for bp_me_xui_arbiter against a queue-based reference model.
module tb_bp_me_xui_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 64;
    localparam int unsigned MW = DW / 8;
    localparam int unsigned MR = 4;
    localparam int unsigned CW = $clog2(MR) + 1;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [1:0][AW-1:0]   req_addr;
    logic [1:0][2:0]      req_cmd;
    logic [1:0]           req_en;
    logic [1:0]           req_rdy;
    logic [1:0][DW-1:0]   req_wdf_data;
    logic [1:0][MW-1:0]   req_wdf_mask;
    logic [1:0]           req_rd_valid;
    logic [DW-1:0]        req_rd_data;
    logic [AW-1:0]        app_addr;
    logic [2:0]           app_cmd;
    logic                 app_en;
    logic                 app_rdy;
    logic                 app_wdf_wren;
    logic [DW-1:0]        app_wdf_data;
    logic [MW-1:0]        app_wdf_mask;
    logic                 app_wdf_end;
    logic                 app_wdf_rdy;
    logic                 app_rd_valid;
    logic [DW-1:0]        app_rd_data;
    logic                 app_rd_end;
    logic [CW-1:0]        outstanding;
    logic                 err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: issuing-port queue, last winner, sticky error.
    int q_m[$];
    int last_m;
    bit err_m;

    bp_me_xui_arbiter #(
        .addr_width_p(AW),
        .data_width_p(DW),
        .max_reads_p (MR)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .req_addr_i         (req_addr),
        .req_cmd_i          (req_cmd),
        .req_en_i           (req_en),
        .req_rdy_o          (req_rdy),
        .req_wdf_data_i     (req_wdf_data),
        .req_wdf_mask_i     (req_wdf_mask),
        .req_rd_data_valid_o(req_rd_valid),
        .req_rd_data_o      (req_rd_data),
        .app_addr_o         (app_addr),
        .app_cmd_o          (app_cmd),
        .app_en_o           (app_en),
        .app_rdy_i          (app_rdy),
        .app_wdf_wren_o     (app_wdf_wren),
        .app_wdf_data_o     (app_wdf_data),
        .app_wdf_mask_o     (app_wdf_mask),
        .app_wdf_end_o      (app_wdf_end),
        .app_wdf_rdy_i      (app_wdf_rdy),
        .app_rd_data_valid_i(app_rd_valid),
        .app_rd_data_i      (app_rd_data),
        .app_rd_data_end_i  (app_rd_end),
        .reads_outstanding_o(outstanding),
        .err_o              (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_payload();
        for (int p = 0; p < 2; p++) begin
            req_addr[p]     = AW'($urandom);
            req_wdf_data[p] = {$urandom, $urandom};
            req_wdf_mask[p] = MW'($urandom);
        end
        app_rd_data = {$urandom, $urandom};
    endtask

    // en: request vector; w0/w1: port issues a write rather than a read.
    task automatic drive(input logic [1:0] en, input bit w0, input bit w1, input bit ardy,
                         input bit wrdy, input bit dv, input bit dend);
        rand_payload();
        req_en       = en;
        req_cmd[0]   = w0 ? 3'b000 : 3'b001;
        req_cmd[1]   = w1 ? 3'b000 : 3'b001;
        app_rdy      = ardy;
        app_wdf_rdy  = wrdy;
        app_rd_valid = dv;
        app_rd_end   = dend;
    endtask

    // Checks outputs for the current inputs, clocks once, then advances the model.
    task automatic cycle();
        int         sel;
        bit         is_w, elig, acc, do_pop;
        logic [1:0] exp_rdy, exp_rdv;
        #1;
        if (req_en == 2'b11) sel = 1 - last_m;
        else                 sel = req_en[1] ? 1 : 0;
        is_w    = (req_cmd[sel] == 3'b000);
        elig    = req_en[sel] && (is_w ? app_wdf_rdy : (q_m.size() < MR));
        acc     = elig && app_rdy;
        exp_rdy = 2'b00;
        if (acc) exp_rdy[sel] = 1'b1;
        exp_rdv = 2'b00;
        if (app_rd_valid && q_m.size() > 0) exp_rdv[q_m[0]] = 1'b1;
        chk("app_en", app_en, elig);
        chk("req_rdy", req_rdy, exp_rdy);
        chk("wdf_wren", app_wdf_wren, elig && is_w);
        chk("wdf_end", app_wdf_end, elig && is_w);
        chk("rd_valid", req_rd_valid, exp_rdv);
        chk("rd_data", req_rd_data, app_rd_data);
        chk("outstanding", outstanding, q_m.size());
        chk("err", err, err_m);
        if (elig) begin
            chk("app_addr", app_addr, req_addr[sel]);
            chk("app_cmd", app_cmd, req_cmd[sel]);
            chk("wdf_data", app_wdf_data, req_wdf_data[sel]);
            chk("wdf_mask", app_wdf_mask, req_wdf_mask[sel]);
        end
        @(posedge clk);
        do_pop = app_rd_valid && app_rd_end && q_m.size() > 0;
        if (app_rd_valid && q_m.size() == 0) err_m = 1'b1;
        if (do_pop) void'(q_m.pop_front());
        if (acc) begin
            last_m = sel;
            if (!is_w) q_m.push_back(sel);
        end
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks the cleared state before any clock arrives.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err, 0);
        chk("rst_app_en", app_en, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_wdf_wren", app_wdf_wren, 0);
        chk("rst_rd_valid", req_rd_valid, 0);
        q_m.delete();
        last_m = 1;
        err_m  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic rand_cycle();
        bit dv;
        if (q_m.size() > 0) dv = ($urandom_range(2) == 0);
        else                dv = ($urandom_range(63) == 0);
        drive(2'($urandom), $urandom_range(1) == 0, $urandom_range(1) == 0,
              $urandom_range(3) != 0, $urandom_range(2) != 0, dv, $urandom_range(3) != 0);
        cycle();
    endtask

    initial begin
        int guard;
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Contention: four reads from both ports alternate 0,1,0,1.
        drive(2'b11, 0, 0, 1, 1, 0, 0);
        #1 chk("first_grant_p0", req_rdy, 2'b01);
        #1;
        for (int i = 0; i < 4; i++) cycle();
        chk("fifo_full", outstanding, 4);

        // Full FIFO: port 0 read stalls, port 1 write still passes.
        drive(2'b01, 0, 0, 1, 1, 0, 0);
        cycle();
        cycle();
        drive(2'b10, 0, 1, 1, 1, 0, 0);
        cycle();
        drive(2'b01, 0, 0, 1, 1, 1, 1);
        cycle();
        drive(2'b01, 0, 0, 1, 1, 0, 0);
        cycle();
        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 0, 0, 1, 1, 1, 1);
            cycle();
        end
        chk("drained", outstanding, 0);

        // Read return: tags 1 then 0, data 0xA then 0xB.
        drive(2'b10, 0, 0, 1, 1, 0, 0);
        cycle();
        drive(2'b01, 0, 0, 1, 1, 0, 0);
        cycle();
        drive(2'b00, 0, 0, 0, 0, 1, 1);
        app_rd_data = 64'hA;
        #1 chk("ret_first_p1", req_rd_valid, 2'b10);
        chk("ret_data_a", req_rd_data, 64'hA);
        cycle();
        drive(2'b00, 0, 0, 0, 0, 1, 1);
        app_rd_data = 64'hB;
        #1 chk("ret_second_p0", req_rd_valid, 2'b01);
        cycle();

        // Write stall until write-data ready rises.
        drive(2'b10, 0, 1, 1, 0, 0, 0);
        cycle();
        cycle();
        drive(2'b10, 0, 1, 1, 1, 0, 0);
        #1 chk("stall_release_wren", app_wdf_wren, 1);
        cycle();
        drive(2'b00, 0, 0, 1, 1, 0, 0);
        cycle();

        // Spurious read data sets a sticky error.
        drive(2'b00, 0, 0, 0, 0, 1, 1);
        cycle();
        chk("spurious_err", err, 1);
        for (int i = 0; i < 3; i++) rand_cycle();
        chk("err_sticky", err, 1);
        do_reset();

        for (int i = 0; i < 300; i++) rand_cycle();
        do_reset();

        // Mid-run reset with three reads outstanding.
        guard = 0;
        while (q_m.size() != 3 && guard < 50) begin
            if (q_m.size() > 3) drive(2'b00, 0, 0, 1, 1, 1, 1);
            else                drive(2'b01, 0, 0, 1, 1, 0, 0);
            cycle();
            guard++;
        end
        if (guard >= 50) begin
            mismatched++;
            $display("FAIL setup_three_reads: observed %0d outstanding expected 3", q_m.size());
        end
        chk("pre_reset_three", outstanding, 3);
        drive(2'b11, 0, 0, 1, 1, 0, 0);
        do_reset();
        #1 chk("post_reset_grant_p0", req_rdy, 2'b01);
        #1;
        cycle();
        drive(2'b00, 0, 0, 0, 0, 1, 1);
        cycle();
        drive(2'b00, 0, 0, 0, 0, 1, 1);
        cycle();
        chk("stale_data_err", err, 1);
        do_reset();

        for (int i = 0; i < 300; i++) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
